// File: rtl/burst_pkg.sv
// Shared definitions for the burst read engine: FSM encoding, command and
// status word field positions, and the discarded all-zero command.
package burst_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FETCH  = 2'd1,
      RUN    = 2'd2,
      REPORT = 2'd3
   } state_t;

   // Command word: {byte_size, byte_addr}
   localparam int          CMD_FIELD_W  = 32;
   localparam int          CMD_ADDR_LSB = 0;
   localparam int          CMD_SIZE_LSB = 32;
   localparam logic [63:0] CMD_ZERO     = 64'h0;

   // Status word: {checksum, 15'b0, err, job_id}
   localparam int          STS_JOB_LSB  = 0;
   localparam int          STS_ERR_BIT  = 16;
   localparam int          STS_CSUM_LSB = 32;
   localparam int          STS_CSUM_W   = 32;

endpackage

// File: rtl/burst_issuer.sv
// Burst issue engine: walks the word address of a job in bursts of at most
// BURST_MAX beats, never letting issued-but-unreturned beats exceed
// MAX_BEATS_INFLIGHT. Holds the request stable while the memory stalls it.
module burst_issuer
   import burst_pkg::*;
#(
   parameter int ADDR_W             = 27,
   parameter int CNT_W              = 32,
   parameter int BURST_MAX          = 128,
   parameter int MAX_BEATS_INFLIGHT = 256
) (
   input  logic              CLOCK,
   input  logic              reset_n,
   input  logic              i_start,
   input  logic [ADDR_W-1:0] i_start_addr,
   input  logic [CNT_W-1:0]  i_beats,
   input  logic              i_run,
   input  logic              i_beat_ret,
   input  logic              i_mem_waitrequest,
   output logic [ADDR_W-1:0] o_mem_address,
   output logic [7:0]        o_mem_burstcount,
   output logic              o_mem_read
);

   localparam int IF_W = $clog2(MAX_BEATS_INFLIGHT + 1);

   logic [ADDR_W-1:0] r_addr;
   logic [CNT_W-1:0]  r_left;
   logic [IF_W-1:0]   r_inflight;
   logic [ADDR_W-1:0] r_mem_address;
   logic [7:0]        r_mem_burstcount;
   logic              r_mem_read;

   logic [7:0]        w_next_burst;
   logic              w_room;
   logic              w_issue;
   logic              w_accept;
   logic [IF_W-1:0]   w_add;
   logic [IF_W-1:0]   w_sub;

   // Size of the next burst, window check and the request/accept strobes
   always_comb begin
      w_next_burst = (r_left < CNT_W'(BURST_MAX)) ? r_left[7:0] : 8'(BURST_MAX);
      w_room       = ({1'b0, r_inflight} + (IF_W+1)'(w_next_burst))
                     <= (IF_W+1)'(MAX_BEATS_INFLIGHT);
      w_issue      = i_run && (r_left != '0) && !r_mem_read && w_room;
      w_accept     = r_mem_read && !i_mem_waitrequest;
      w_add        = w_accept ? IF_W'(r_mem_burstcount) : '0;
      w_sub        = i_beat_ret ? IF_W'(1) : '0;
   end

   // Job cursor, outstanding-beat count and the registered memory request
   always_ff @(posedge CLOCK or negedge reset_n) begin
      if (!reset_n) begin
         r_addr           <= '0;
         r_left           <= '0;
         r_inflight       <= '0;
         r_mem_address    <= '0;
         r_mem_burstcount <= '0;
         r_mem_read       <= 1'b0;
      end else begin
         if (i_start) begin
            r_addr     <= i_start_addr;
            r_left     <= i_beats;
            r_inflight <= '0;
         end else begin
            // Accepted bursts and returned beats can land together; net them.
            r_inflight <= r_inflight + w_add - w_sub;
         end
         if (w_issue) begin
            r_mem_read       <= 1'b1;
            r_mem_address    <= r_addr;
            r_mem_burstcount <= w_next_burst;
            r_addr           <= r_addr + ADDR_W'(w_next_burst);
            r_left           <= r_left - CNT_W'(w_next_burst);
         end else if (w_accept) begin
            r_mem_read <= 1'b0;
         end
      end
   end

   assign o_mem_address    = r_mem_address;
   assign o_mem_burstcount = r_mem_burstcount;
   assign o_mem_read       = r_mem_read;

endmodule

// File: rtl/burst_read_engine.sv
// Burst read engine: fetches {byte_size, byte_addr} jobs from a command
// port, streams the addressed SDRAM beats out unthrottled, and reports a
// per-job status word carrying a 32-bit checksum, an error flag and job id.
module burst_read_engine
   import burst_pkg::*;
#(
   parameter int DATA_W             = 256,
   parameter int ADDR_W             = 27,
   parameter int BURST_MAX          = 128,
   parameter int MAX_BEATS_INFLIGHT = 256,
   parameter int JOB_W              = 16
) (
   input  logic              CLOCK,
   input  logic              reset_n,
   output logic              cmd_read,
   input  logic [63:0]       cmd_readdata,
   input  logic              cmd_waitrequest,
   output logic              sts_write,
   output logic [63:0]       sts_writedata,
   input  logic              sts_waitrequest,
   output logic [ADDR_W-1:0] mem_address,
   output logic [7:0]        mem_burstcount,
   output logic              mem_read,
   input  logic              mem_waitrequest,
   input  logic [DATA_W-1:0] mem_readdata,
   input  logic              mem_readdatavalid,
   output logic              beat_valid,
   output logic [DATA_W-1:0] beat_data,
   output logic              beat_last,
   output logic              busy
);

   localparam int SHIFT = $clog2(DATA_W / 8);
   localparam int CNT_W = 32;

   state_t              r_state;
   state_t              w_next;
   logic [CNT_W-1:0]    r_total;
   logic [CNT_W-1:0]    r_rcvd;
   logic [31:0]         r_checksum;
   logic                r_err;
   logic [JOB_W-1:0]    r_job_id;
   logic                r_beat_valid;
   logic [DATA_W-1:0]   r_beat_data;
   logic                r_beat_last;

   logic [CMD_FIELD_W-1:0] w_cmd_addr;
   logic [CMD_FIELD_W-1:0] w_cmd_size;
   logic [CNT_W-1:0]       w_cmd_beats;
   logic [ADDR_W-1:0]      w_cmd_waddr;
   logic                   w_rdv_run;
   logic                   w_last_beat;
   logic                   w_start;
   logic                   w_zero_job;
   logic                   w_sts_done;
   logic [63:0]            w_sts_word;

   // Decode the command word into a word address and a beat count
   always_comb begin
      w_cmd_addr  = cmd_readdata[CMD_ADDR_LSB +: CMD_FIELD_W];
      w_cmd_size  = cmd_readdata[CMD_SIZE_LSB +: CMD_FIELD_W];
      w_cmd_beats = CNT_W'(w_cmd_size >> SHIFT);
      w_cmd_waddr = ADDR_W'(w_cmd_addr >> SHIFT);
      w_rdv_run   = mem_readdatavalid && (r_state == RUN);
      w_last_beat = (r_rcvd == r_total - CNT_W'(1));
   end

   // Next-state logic and job start/finish strobes
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // through the case leaves a variable unassigned and infers a latch.
      w_next     = r_state;
      w_start    = 1'b0;
      w_zero_job = 1'b0;
      w_sts_done = 1'b0;
      case (r_state)
         IDLE: w_next = FETCH;
         FETCH: begin
            if (!cmd_waitrequest && (cmd_readdata != CMD_ZERO)) begin
               if (w_cmd_beats == '0) begin
                  w_zero_job = 1'b1;
                  w_next     = REPORT;
               end else begin
                  w_start = 1'b1;
                  w_next  = RUN;
               end
            end
         end
         RUN: begin
            if (w_rdv_run && w_last_beat) w_next = REPORT;
         end
         REPORT: begin
            if (!sts_waitrequest) begin
               w_sts_done = 1'b1;
               w_next     = IDLE;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge CLOCK or negedge reset_n) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of block ordering.
      if (!reset_n) r_state <= IDLE;
      else          r_state <= w_next;
   end

   // Beat output register, job bookkeeping and checksum accumulation
   always_ff @(posedge CLOCK or negedge reset_n) begin
      if (!reset_n) begin
         r_total      <= '0;
         r_rcvd       <= '0;
         r_checksum   <= '0;
         r_err        <= 1'b0;
         r_job_id     <= '0;
         r_beat_valid <= 1'b0;
         r_beat_data  <= '0;
         r_beat_last  <= 1'b0;
      end else begin
         r_beat_valid <= w_rdv_run;
         r_beat_last  <= w_rdv_run && w_last_beat;
         if (w_rdv_run) begin
            r_beat_data <= mem_readdata;
            r_checksum  <= r_checksum + mem_readdata[31:0];
            r_rcvd      <= r_rcvd + CNT_W'(1);
         end
         if (w_start || w_zero_job) begin
            r_total    <= w_cmd_beats;
            r_rcvd     <= '0;
            r_checksum <= '0;
            r_err      <= w_zero_job;
         end
         if (w_sts_done) r_job_id <= r_job_id + JOB_W'(1);
      end
   end

   // Status word assembly, driven only while it is being offered
   always_comb begin
      w_sts_word = '0;
      w_sts_word[STS_JOB_LSB +: JOB_W]        = r_job_id;
      w_sts_word[STS_ERR_BIT]                 = r_err;
      w_sts_word[STS_CSUM_LSB +: STS_CSUM_W]  = r_checksum;
   end

   burst_issuer #(
      .ADDR_W             (ADDR_W),
      .CNT_W              (CNT_W),
      .BURST_MAX          (BURST_MAX),
      .MAX_BEATS_INFLIGHT (MAX_BEATS_INFLIGHT)
   ) u_issuer (
      .CLOCK             (CLOCK),
      .reset_n           (reset_n),
      .i_start           (w_start),
      .i_start_addr      (w_cmd_waddr),
      .i_beats           (w_cmd_beats),
      .i_run             (r_state == RUN),
      .i_beat_ret        (w_rdv_run),
      .i_mem_waitrequest (mem_waitrequest),
      .o_mem_address     (mem_address),
      .o_mem_burstcount  (mem_burstcount),
      .o_mem_read        (mem_read)
   );

   assign cmd_read      = (r_state == FETCH);
   assign sts_write     = (r_state == REPORT);
   assign sts_writedata = sts_write ? w_sts_word : 64'h0;
   assign busy          = (r_state == RUN) || (r_state == REPORT);
   assign beat_valid    = r_beat_valid;
   assign beat_data     = r_beat_data;
   assign beat_last     = r_beat_last;

endmodule

// File: tb/tb_burst_read_engine.sv
// Scoreboard bench for burst_read_engine. Each queued command expands into
// expected bursts, beats and a status word; monitors compare as the DUT
// presents them. Memory contents are a fixed function of word address.
module tb_burst_read_engine;

   localparam int DATA_W = 256;
   localparam int ADDR_W = 27;
   localparam int BMAX   = 128;
   localparam int MAXIF  = 256;
   localparam int JOB_W  = 16;
   localparam int BPB    = DATA_W / 8;

   logic              CLOCK = 1'b0;
   logic              reset_n = 1'b1;
   logic              cmd_read;
   logic [63:0]       cmd_readdata = '0;
   logic              cmd_waitrequest = 1'b0;
   logic              sts_write;
   logic [63:0]       sts_writedata;
   logic              sts_waitrequest = 1'b0;
   logic [ADDR_W-1:0] mem_address;
   logic [7:0]        mem_burstcount;
   logic              mem_read;
   logic              mem_waitrequest = 1'b0;
   logic [DATA_W-1:0] mem_readdata = '0;
   logic              mem_readdatavalid = 1'b0;
   logic              beat_valid;
   logic [DATA_W-1:0] beat_data;
   logic              beat_last;
   logic              busy;

   always #5 CLOCK = ~CLOCK;

   burst_read_engine #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BURST_MAX(BMAX),
      .MAX_BEATS_INFLIGHT(MAXIF), .JOB_W(JOB_W)
   ) dut (
      .CLOCK(CLOCK), .reset_n(reset_n),
      .cmd_read(cmd_read), .cmd_readdata(cmd_readdata), .cmd_waitrequest(cmd_waitrequest),
      .sts_write(sts_write), .sts_writedata(sts_writedata), .sts_waitrequest(sts_waitrequest),
      .mem_address(mem_address), .mem_burstcount(mem_burstcount), .mem_read(mem_read),
      .mem_waitrequest(mem_waitrequest), .mem_readdata(mem_readdata),
      .mem_readdatavalid(mem_readdatavalid),
      .beat_valid(beat_valid), .beat_data(beat_data), .beat_last(beat_last), .busy(busy)
   );

   typedef struct { logic [ADDR_W-1:0] addr; int count; } burst_t;
   typedef struct { logic [DATA_W-1:0] data; logic last; } beat_t;

   burst_t      exp_bursts[$];
   beat_t       exp_beats[$];
   logic [63:0] exp_sts[$];
   logic [63:0] cmd_q[$];
   burst_t      pend[$];

   int checks = 0;
   int errors = 0;
   int model_job_id = 0;

   int rdv_pct = 60, mem_wait_pct = 20, cmd_wait_pct = 20, sts_wait_pct = 20;
   bit rdv_enable = 1'b1;
   int force_mem_wait = 0, force_sts_wait = 0, stray_left = 0, pend_idx = 0;
   bit stray_phase = 1'b0;

   int bursts_acc = 0, beats_seen = 0, outstanding = 0;

   function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
      logic [DATA_W-1:0] d;
      for (int k = 0; k < DATA_W / 32; k++)
         d[k*32 +: 32] = (32'(a) * 32'h9E3779B1) ^ (32'(k) * 32'h85EBCA6B) ^ 32'h5A5A0F0F;
      return d;
   endfunction

   task automatic check(input string name, input logic [DATA_W-1:0] act,
                        input logic [DATA_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Reference model: a job is a contiguous run of floor(size/BPB) words
   // starting at addr/BPB, cut into BMAX-sized bursts plus one remainder.
   task automatic push_job(input logic [31:0] size, input logic [31:0] addr);
      logic [63:0]       w;
      int unsigned       beats, rem, c;
      logic [ADDR_W-1:0] a, ba;
      logic [DATA_W-1:0] d;
      logic [31:0]       csum;
      logic [15:0]       jid;
      beat_t             bt;
      burst_t            bb;
      w = {size, addr};
      cmd_q.push_back(w);
      if (w == 64'h0) return;
      beats = size / BPB;
      a     = ADDR_W'(addr / BPB);
      csum  = '0;
      for (int unsigned i = 0; i < beats; i++) begin
         d       = mem_word(a + ADDR_W'(i));
         bt.data = d;
         bt.last = (i == beats - 1);
         exp_beats.push_back(bt);
         csum    = csum + d[31:0];
      end
      rem = beats;
      ba  = a;
      while (rem > 0) begin
         c        = (rem < BMAX) ? rem : BMAX;
         bb.addr  = ba;
         bb.count = int'(c);
         exp_bursts.push_back(bb);
         ba  = ba + ADDR_W'(c);
         rem = rem - c;
      end
      jid = model_job_id[15:0];
      exp_sts.push_back({csum, 15'b0, (beats == 0), jid});
      model_job_id = (model_job_id + 1) % (1 << JOB_W);
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n;
      n = 0;
      while ((cmd_q.size() + exp_bursts.size() + exp_beats.size() + exp_sts.size()) != 0
             && n < budget) begin
         @(negedge CLOCK);
         n++;
      end
      checks++;
      if ((cmd_q.size() + exp_bursts.size() + exp_beats.size() + exp_sts.size()) != 0) begin
         errors++;
         $display("FAIL %s timeout: bursts left %0d beats left %0d status left %0d required 0",
                  name, exp_bursts.size(), exp_beats.size(), exp_sts.size());
      end
      repeat (3) @(negedge CLOCK);
   endtask

   task automatic check_outputs_zero(input string name);
      check({name, "_ctl"}, {cmd_read, sts_write, sts_writedata, mem_address, mem_burstcount,
                             mem_read, beat_valid, beat_last, busy}, '0);
      check({name, "_data"}, beat_data, '0);
   endtask

   // Stimulus drivers: command source, status sink and SDRAM with 1-cycle
   // minimum read latency; all driven just after the falling edge.
   always @(negedge CLOCK) begin
      #1;
      if (!reset_n) begin
         cmd_waitrequest   = 1'b0;
         cmd_readdata      = '0;
         sts_waitrequest   = 1'b0;
         mem_waitrequest   = 1'b0;
         mem_readdatavalid = 1'b0;
         mem_readdata      = '0;
         pend.delete();
         pend_idx = 0;
      end else begin
         cmd_waitrequest = ($urandom_range(0, 99) < cmd_wait_pct);
         cmd_readdata    = (cmd_q.size() > 0) ? cmd_q[0] : 64'h0;
         if (cmd_read && !cmd_waitrequest && cmd_q.size() > 0) void'(cmd_q.pop_front());

         if (sts_write && force_sts_wait > 0) begin
            sts_waitrequest = 1'b1;
            force_sts_wait--;
         end else begin
            sts_waitrequest = ($urandom_range(0, 99) < sts_wait_pct);
         end

         if (stray_left > 0) begin
            mem_readdatavalid = 1'b1;
            mem_readdata      = {8{$urandom}};
            stray_left--;
         end else if (rdv_enable && pend.size() > 0 && $urandom_range(0, 99) < rdv_pct) begin
            mem_readdatavalid = 1'b1;
            mem_readdata      = mem_word(pend[0].addr + ADDR_W'(pend_idx));
            pend_idx++;
            if (pend_idx == pend[0].count) begin
               void'(pend.pop_front());
               pend_idx = 0;
            end
         end else begin
            mem_readdatavalid = 1'b0;
            mem_readdata      = {8{$urandom}};
         end

         if (mem_read && force_mem_wait > 0) begin
            mem_waitrequest = 1'b1;
            force_mem_wait--;
         end else begin
            mem_waitrequest = ($urandom_range(0, 99) < mem_wait_pct);
         end
         if (mem_read && !mem_waitrequest) pend.push_back('{mem_address, int'(mem_burstcount)});
      end
   end

   // Monitor: previous-cycle outputs plus still-held inputs describe the
   // handshakes taken at the rising edge just passed.
   logic              p_mem_read = 1'b0;
   logic [ADDR_W-1:0] p_addr = '0;
   logic [7:0]        p_cnt = '0;
   logic              p_sts_write = 1'b0;
   logic [63:0]       p_sts_data = '0;

   always @(negedge CLOCK) begin
      burst_t eb;
      beat_t  et;
      logic [63:0] es;
      if (!reset_n) begin
         p_mem_read  = 1'b0;
         p_sts_write = 1'b0;
         outstanding = 0;
      end else begin
         if (p_mem_read && !mem_waitrequest) begin
            bursts_acc++;
            check("inflight_limit", (outstanding + int'(p_cnt)) <= MAXIF, 1);
            outstanding += int'(p_cnt);
            if (exp_bursts.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL burst_unexpected addr=%0h count=%0d required none", p_addr, p_cnt);
            end else begin
               eb = exp_bursts.pop_front();
               check("burst_addr", p_addr, eb.addr);
               check("burst_count", p_cnt, eb.count);
            end
         end
         if (p_mem_read && mem_waitrequest)
            check("mem_hold", {mem_read, mem_address, mem_burstcount}, {1'b1, p_addr, p_cnt});
         if (mem_readdatavalid && !stray_phase) outstanding--;

         if (p_sts_write && !sts_waitrequest) begin
            if (exp_sts.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL status_unexpected data=%0h required none", p_sts_data);
            end else begin
               es = exp_sts.pop_front();
               check("status_word", p_sts_data, es);
            end
         end
         if (p_sts_write && sts_waitrequest)
            check("sts_hold", {sts_write, sts_writedata}, {1'b1, p_sts_data});
         if (sts_write) check("report_no_fetch", cmd_read, 0);

         if (beat_valid) begin
            beats_seen++;
            if (exp_beats.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL beat_unexpected data=%0h last=%0b required none", beat_data, beat_last);
            end else begin
               et = exp_beats.pop_front();
               check("beat_data", beat_data, et.data);
               check("beat_last", beat_last, et.last);
            end
         end

         p_mem_read  = mem_read;
         p_addr      = mem_address;
         p_cnt       = mem_burstcount;
         p_sts_write = sts_write;
         p_sts_data  = sts_writedata;
      end
   end

   initial begin
      int b0, s0, n;
      logic [31:0] sz;
      int nb;

      #2 reset_n = 1'b0;
      repeat (3) @(negedge CLOCK);
      check_outputs_zero("reset_state");
      #2 reset_n = 1'b1;
      repeat (2) @(negedge CLOCK);

      // 128-beat job at byte 0x2000: one burst at word 0x100
      push_job(32'h1000, 32'h2000);
      wait_idle("job_128", 4000);

      // First burst stalled for 5 cycles by the memory
      force_mem_wait = 5;
      b0 = bursts_acc;
      push_job(32'h1000, 32'h0);
      wait_idle("stalled_burst", 4000);
      check("stalled_one_burst", bursts_acc - b0, 1);

      // 257 beats with no returns: window admits only 128+128
      rdv_enable = 1'b0;
      b0 = bursts_acc;
      s0 = beats_seen;
      push_job(32'h2020, 32'h4000);
      repeat (400) @(negedge CLOCK);
      check("window_two_bursts", bursts_acc - b0, 2);
      check("window_no_beats", beats_seen - s0, 0);
      rdv_enable = 1'b1;
      wait_idle("job_257", 6000);
      check("job_257_bursts", bursts_acc - b0, 3);

      // Status held off for 10 cycles
      force_sts_wait = 10;
      push_job(32'h0200, 32'h0001_0040);
      wait_idle("sts_stall", 4000);

      // Randomised jobs, including zero words and back-to-back commands
      for (int j = 0; j < 14; j++) begin
         rdv_pct      = $urandom_range(25, 100);
         mem_wait_pct = $urandom_range(0, 60);
         cmd_wait_pct = $urandom_range(0, 60);
         sts_wait_pct = $urandom_range(0, 60);
         nb = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 3) : $urandom_range(1, 300);
         sz = 32'(nb * BPB) + 32'($urandom_range(0, BPB - 1));
         if (j % 5 == 4) push_job(32'h0, 32'h0);
         push_job(sz, $urandom);
         if (j % 3 == 2) push_job(32'(BPB * $urandom_range(1, 50)), $urandom);
         wait_idle("random_job", 12000);
      end

      // Reset mid-job after 40 beats, then stray returns
      rdv_pct = 60;
      mem_wait_pct = 20;
      s0 = beats_seen;
      push_job(32'h1000, 32'h8000);
      n = 0;
      while (beats_seen - s0 < 40 && n < 3000) begin
         @(negedge CLOCK);
         n++;
      end
      check("reach_40_beats", beats_seen - s0 >= 40, 1);
      #2 reset_n = 1'b0;
      #1 check_outputs_zero("midjob_reset");
      cmd_q.delete();
      exp_bursts.delete();
      exp_beats.delete();
      exp_sts.delete();
      model_job_id = 0;
      stray_phase  = 1'b1;
      repeat (3) @(negedge CLOCK);
      #2 reset_n = 1'b1;
      s0 = beats_seen;
      b0 = bursts_acc;
      stray_left = 88;
      n = 0;
      while (stray_left > 0 && n < 500) begin
         @(negedge CLOCK);
         n++;
      end
      repeat (3) @(negedge CLOCK);
      check("stray_no_beats", beats_seen - s0, 0);
      check("stray_no_bursts", bursts_acc - b0, 0);
      check("restart_fetch", {cmd_read, busy, mem_read}, 3'b100);
      stray_phase = 1'b0;

      // Zero-beat job after reset: error flag, job id 0; next job id 1
      b0 = bursts_acc;
      push_job(32'h10, 32'h0);
      wait_idle("zero_beat_job", 2000);
      check("zero_beat_no_burst", bursts_acc - b0, 0);
      push_job(32'h0800, 32'h0000_3000);
      wait_idle("after_zero_job", 4000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/burst_read_engine.md
BURST_READ_ENGINE -- requirements
Module: burst_read_engine

Interface
REQ-001 Parameters SHALL be DATA_W 256 (SDRAM beat width, bits), ADDR_W 27 (word address width), BURST_MAX 128 (max beats per burst, ≤255), MAX_BEATS_INFLIGHT 256 (issued-not-returned beat limit, ≥BURST_MAX), JOB_W 16 (job id width).
REQ-002 Ports SHALL be: CLOCK in 1 clock; reset_n in 1 async active-low reset; cmd_read out 1; cmd_readdata in 64; cmd_waitrequest in 1; sts_write out 1; sts_writedata out 64; sts_waitrequest in 1; mem_address out ADDR_W; mem_burstcount out 8; mem_read out 1; mem_waitrequest in 1; mem_readdata in DATA_W; mem_readdatavalid in 1; beat_valid out 1; beat_data out DATA_W; beat_last out 1; busy out 1.
REQ-003 Reset SHALL be reset_n, asynchronous, active-low; clock SHALL be CLOCK.

Function
REQ-004 Command word SHALL be {byte_size[63:32], byte_addr[31:0]}; the all-zero word SHALL be discarded with no other effect.
REQ-005 Word address SHALL be byte_addr/(DATA_W/8), truncated to ADDR_W; beat total SHALL be byte_size/(DATA_W/8), floor.
REQ-006 FSM states SHALL be IDLE, FETCH, RUN, REPORT; reset enters IDLE.
REQ-007 IDLE→FETCH unconditionally next cycle; FETCH holds cmd_read=1 until a cycle with !cmd_waitrequest; a nonzero word then → RUN (or → REPORT with error flag when beat total = 0); a zero word stays in FETCH.
REQ-008 In RUN a burst SHALL be issued when beats left to issue > 0, mem_read is low, and inflight + next_burst ≤ MAX_BEATS_INFLIGHT, where next_burst = min(BURST_MAX, beats left to issue).
REQ-009 mem_address, mem_burstcount, mem_read SHALL stay stable while mem_read=1 && mem_waitrequest=1; on acceptance, address advances by next_burst and mem_read drops the following cycle.
REQ-010 Inflight counter SHALL add the accepted burstcount and subtract 1 per mem_readdatavalid; both in one cycle SHALL net correctly.
REQ-011 Every mem_readdatavalid in RUN SHALL produce beat_valid=1 one cycle later with beat_data = mem_readdata (registered, no backpressure); beat_last=1 on the job's final beat.
REQ-012 Checksum SHALL be the mod-2^32 sum of mem_readdata[31:0] over all job beats; cleared on job start.
REQ-013 After the final beat, RUN → REPORT; sts_writedata = {checksum[31:0], 15'b0, err, job_id[JOB_W-1:0]}, sts_write held until !sts_waitrequest, then → IDLE and job_id increments (wrapping at 2^JOB_W).
REQ-014 mem_readdatavalid outside RUN SHALL be ignored (no beat_valid, no counter change).
REQ-015 busy SHALL be 1 in RUN and REPORT, 0 otherwise.
REQ-016 A job whose beat total is not a multiple of BURST_MAX SHALL end with one short burst of the remainder.

Reset
REQ-017 On reset_n low all outputs SHALL be 0 (address, burstcount, data, flags), counters and job_id 0, state IDLE, immediately and regardless of state; SDRAM beats returned after reset are dropped per REQ-014.

Structure
REQ-018 FSM state encoding, command/status field offsets, and the zero-command constant SHALL live in shared package burst_pkg.
REQ-019 Burst issue logic (address, remaining, inflight counters) SHALL be sub-module burst_issuer; FSM, checksum and beat output stay in top.

Verification
REQ-020 Cmd {size=0x1000, addr=0x2000} (DATA_W 256): 128 beats, one burst addr 0x100 count 128, checksum correct, status job_id 0 err 0.
REQ-021 Cmd size=0x2020 (257 beats), MAX_BEATS_INFLIGHT 256: bursts 128,128,1; third issues only after ≥1 beat returns; beat_last on beat 257.
REQ-022 mem_waitrequest held 5 cycles on first burst: address/burstcount/read stable all 5 cycles, exactly one burst accepted.
REQ-023 Cmd size=0x10 (0 beats): no mem_read, status err=1, job_id 0; next job reports job_id 1.
REQ-024 sts_waitrequest held 10 cycles in REPORT: sts_write/data stable, no cmd_read until accepted.
REQ-025 reset_n low mid-job after 40 beats, then 88 stray readdatavalid: all outputs 0, no beat_valid, FSM restarts in IDLE.
